cdc_hs_tx: RTL and testbench
============================

CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 Parameter BUS_WIDTH, default 8, SHALL set the width of the transferred data word.
REQ-002 Parameter NUM_STAGES, default 2, minimum 2, SHALL set the depth of the ACK synchronizer.
REQ-003 CLK  input  1  SHALL be the single source-domain clock; all state updates occur on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-low reset.
REQ-005 IN_DATA  input  BUS_WIDTH  SHALL carry the word offered for transfer.
REQ-006 IN_VALID  input  1  SHALL mark IN_DATA as valid.
REQ-007 IN_READY  output  1  SHALL indicate that a word can be accepted this cycle.
REQ-008 ASYNC_ACK  input  1  SHALL be the acknowledge from the destination domain, asynchronous to CLK.
REQ-009 TX_DATA  output  BUS_WIDTH  SHALL be the registered data bus, held stable for the whole handshake.
REQ-010 TX_REQ  output  1  SHALL be the registered four-phase request level sent to the destination.
REQ-011 TX_DONE  output  1  SHALL pulse for one cycle when a handshake completes.

Function
REQ-012 ASYNC_ACK SHALL pass through a chain of NUM_STAGES flops; the last stage output is ack_s.
REQ-013 ACK timing: when ASYNC_ACK is first sampled at edge j, ack_s SHALL be valid after edge j+NUM_STAGES-1, and the FSM SHALL react at edge j+NUM_STAGES.
REQ-014 The FSM SHALL have four states: IDLE, SETUP, WAIT_ACK and WAIT_NACK.
REQ-015 IN_READY SHALL be 1 only in IDLE; it SHALL be a decode of the registered state, with no combinational path from IN_VALID.
REQ-016 In IDLE, when IN_VALID=1 at edge k: TX_DATA SHALL load IN_DATA at edge k, and the FSM SHALL move to SETUP.
REQ-017 In SETUP, when ack_s=0: at the next edge TX_REQ SHALL go to 1 and the FSM SHALL move to WAIT_ACK. Data therefore leads REQ by at least one cycle.
REQ-018 In SETUP, when ack_s=1 (stale ACK): the FSM SHALL hold SETUP with TX_REQ=0 until ack_s=0.
REQ-019 In WAIT_ACK, when ack_s=1: at the next edge TX_REQ SHALL go to 0 and the FSM SHALL move to WAIT_NACK.
REQ-020 In WAIT_NACK, when ack_s=0: at the next edge the FSM SHALL move to IDLE and TX_DONE SHALL be 1 for exactly that one cycle.
REQ-021 TX_DATA SHALL change only on an accept (REQ-016) or on reset; IN_DATA and IN_VALID activity in any non-IDLE state SHALL be ignored.
REQ-022 There SHALL be no timeout; WAIT_ACK and WAIT_NACK SHALL wait indefinitely.
REQ-023 Back-to-back transfers: IN_VALID held at 1 SHALL be accepted on the first edge at which the FSM is in IDLE.

Reset
REQ-024 While RST=0 at a rising edge, the following SHALL hold after that edge: state=IDLE, TX_REQ=0, TX_DATA=0, TX_DONE=0, all synchronizer flops=0, IN_READY=1.
REQ-025 Reset asserted in any state, including mid-handshake, SHALL take effect at the next edge and abandon the transfer without issuing TX_DONE.

Structure
REQ-026 The FSM state encoding and the minimum NUM_STAGES constant SHALL live in the shared CDC package.
REQ-027 The ACK synchronizer SHALL be one sub-module, hs_ack_sync: width 1, NUM_STAGES flops, synchronous active-low RST.

Verification
All scenarios use BUS_WIDTH=8, NUM_STAGES=2, CLK period 50 ns.
REQ-028 Reset: RST=0 for 2 edges -> TX_REQ=0, TX_DATA=8'h00, IN_READY=1, TX_DONE=0.
REQ-029 Single transfer: IN_DATA=8'hA5 accepted at edge 0, with the bench driving ASYNC_ACK = TX_REQ delayed one cycle -> TX_DATA=A5 after edge 0; TX_REQ high from edge 1 to edge 5 (4 cycles); TX_DONE=1 and IN_READY=1 after edge 9.
REQ-030 Busy hold: IN_VALID kept at 1 with IN_DATA stepping through 3C, 5A, FF during the A5 handshake -> TX_DATA stays A5 until TX_DONE; the next accept captures the value present at that edge.
REQ-031 Stale ACK: ASYNC_ACK=1 at reset release, then a word accepted -> FSM holds SETUP with TX_REQ=0; TX_REQ rises 3 edges after ASYNC_ACK is driven to 0.
REQ-032 Reset mid-handshake: RST=0 for one edge while in WAIT_ACK -> after that edge TX_REQ=0, TX_DATA=0, IN_READY=1, and no TX_DONE pulse.
REQ-033 Back-to-back: IN_VALID held at 1 for two words 11, 22 -> exactly two TX_DONE pulses; the second accept occurs the edge after the first TX_DONE.

Source files
------------

// File: rtl/cdc_hs_tx_pkg.sv
// Shared definitions for the four-phase CDC handshake transmitter:
// FSM state encoding and the minimum ACK synchronizer depth.
package cdc_hs_tx_pkg;

    localparam int MIN_NUM_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETUP     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_NACK = 2'd3
    } hs_state_e;

endpackage : cdc_hs_tx_pkg

// File: rtl/cdc_hs_tx_ack_sync.sv
// Multi-flop synchronizer bringing the destination ACK level into the
// source clock domain; the last stage is the only output.
module hs_ack_sync
    import cdc_hs_tx_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [NUM_STAGES-1:0] sync_q;

    if (NUM_STAGES < MIN_NUM_STAGES) begin : g_bad_depth
        $error("hs_ack_sync: NUM_STAGES below minimum");
    end

    // NOTE: sequential state always uses non-blocking assignment so every
    // stage samples the previous value of its neighbour on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[NUM_STAGES-1];

endmodule : hs_ack_sync

// File: rtl/cdc_hs_tx.sv
// Source side of a four-phase REQ/ACK handshake: captures a word, holds it
// stable on TX_DATA, and sequences TX_REQ against the synchronized ACK.
module cdc_hs_tx
    import cdc_hs_tx_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic                 ASYNC_ACK,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 TX_REQ,
    output logic                 TX_DONE
);

    hs_state_e            state_q, state_d;
    logic [BUS_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                 tx_req_q, tx_req_d;
    logic                 tx_done_q, tx_done_d;
    logic                 ack_s;

    hs_ack_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .clk    (CLK),
        .rst_n  (RST),
        .async_i(ASYNC_ACK),
        .sync_o (ack_s)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_req_d  = tx_req_q;
        tx_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    tx_data_d = IN_DATA;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // A stale ACK from a previous transfer must clear before REQ.
                if (!ack_s) begin
                    tx_req_d = 1'b1;
                    state_d  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_WAIT_NACK;
                end
            end
            ST_WAIT_NACK: begin
                if (!ack_s) begin
                    tx_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_req_q  <= tx_req_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign IN_READY = (state_q == ST_IDLE);
    assign TX_DATA  = tx_data_q;
    assign TX_REQ   = tx_req_q;
    assign TX_DONE  = tx_done_q;

endmodule : cdc_hs_tx

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: per-edge vector table for the basic and
// busy-hold handshakes, plus sequences for back-to-back, stale ACK and reset.
module tb_cdc_hs_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic       ASYNC_ACK;
    logic [7:0] TX_DATA;
    logic       TX_REQ;
    logic       TX_DONE;

    int n_cmp  = 0;
    int n_fail = 0;
    bit auto_ack = 1'b0;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_req;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_done;
    } vec_t;

    vec_t vq[$];

    cdc_hs_tx #(
        .BUS_WIDTH (8),
        .NUM_STAGES(2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .ASYNC_ACK(ASYNC_ACK),
        .TX_DATA  (TX_DATA),
        .TX_REQ   (TX_REQ),
        .TX_DONE  (TX_DONE)
    );

    always #25 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Destination model: ACK follows TX_REQ one cycle late when enabled.
    task automatic tick();
        logic req_before;
        req_before = TX_REQ;
        @(posedge CLK);
        #1;
        if (auto_ack) ASYNC_ACK = req_before;
    endtask

    task automatic add(input int n, input logic v, input logic [7:0] d, input logic req,
                       input logic [7:0] xd, input logic rdy, input logic dn);
        vec_t e;
        e = '{v, d, req, xd, rdy, dn};
        for (int i = 0; i < n; i++) vq.push_back(e);
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int k;
        k = 0;
        while (TX_DONE !== 1'b1 && k < max_cycles) begin
            tick();
            k++;
        end
        check(name, {7'b0, TX_DONE}, 8'h01);
    endtask

    initial begin
        int  done_cnt;
        bit  done_seen;

        RST = 1'b0; IN_DATA = 8'h00; IN_VALID = 1'b0; ASYNC_ACK = 1'b0;

        // Reset
        tick(); tick();
        check("rst_req",   {7'b0, TX_REQ},   8'h00);
        check("rst_data",  TX_DATA,          8'h00);
        check("rst_ready", {7'b0, IN_READY}, 8'h01);
        check("rst_done",  {7'b0, TX_DONE},  8'h00);
        RST = 1'b1; auto_ack = 1'b1;
        tick(); tick();

        // Single A5 transfer, edges 0..10
        add(1, 1'b1, 8'hA5, 1'b1 ^ 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(3, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(4, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1);
        add(1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0);
        // Busy hold: IN_VALID stays high with changing data during A5
        add(1, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'h3C, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'h5A, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'hFF, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'h3C, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'h5A, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'hFF, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'h5A, 1'b0, 8'hA5, 1'b0, 1'b0);
        add(1, 1'b1, 8'hFF, 1'b0, 8'hA5, 1'b1, 1'b1);
        add(1, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0);
        add(4, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0);
        add(4, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0);
        add(1, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1);
        add(1, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            IN_VALID = vq[i].valid;
            IN_DATA  = vq[i].data;
            tick();
            check($sformatf("vec%0d_req", i),   {7'b0, TX_REQ},   {7'b0, vq[i].exp_req});
            check($sformatf("vec%0d_data", i),  TX_DATA,          vq[i].exp_data);
            check($sformatf("vec%0d_ready", i), {7'b0, IN_READY}, {7'b0, vq[i].exp_ready});
            check($sformatf("vec%0d_done", i),  {7'b0, TX_DONE},  {7'b0, vq[i].exp_done});
        end
        IN_VALID = 1'b0;

        // Back-to-back 11, 22 with IN_VALID held
        IN_VALID = 1'b1; IN_DATA = 8'h11;
        tick();
        check("b2b_acc1_data",  TX_DATA,          8'h11);
        check("b2b_acc1_ready", {7'b0, IN_READY}, 8'h00);
        IN_DATA = 8'h22;
        wait_done("b2b_done1", 30);
        check("b2b_done1_data", TX_DATA, 8'h11);
        tick();
        check("b2b_acc2_data",  TX_DATA,          8'h22);
        check("b2b_acc2_ready", {7'b0, IN_READY}, 8'h00);
        IN_VALID = 1'b0;
        done_cnt = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (TX_DONE === 1'b1) done_cnt++;
        end
        check("b2b_done_count", 8'(done_cnt), 8'h02);

        // Stale ACK held through reset release
        auto_ack = 1'b0; ASYNC_ACK = 1'b1; RST = 1'b0;
        tick(); tick();
        RST = 1'b1;
        tick(); tick(); tick();
        check("stale_idle_ready", {7'b0, IN_READY}, 8'h01);
        IN_VALID = 1'b1; IN_DATA = 8'h6C;
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stale_hold_req",   {7'b0, TX_REQ},   8'h00);
            check("stale_hold_ready", {7'b0, IN_READY}, 8'h00);
        end
        check("stale_data", TX_DATA, 8'h6C);
        ASYNC_ACK = 1'b0;
        tick();
        check("stale_rel1_req", {7'b0, TX_REQ}, 8'h00);
        tick();
        check("stale_rel2_req", {7'b0, TX_REQ}, 8'h00);
        tick();
        check("stale_rel3_req", {7'b0, TX_REQ}, 8'h01);
        auto_ack = 1'b1;
        wait_done("stale_done", 30);
        tick();

        // Reset in WAIT_ACK abandons the transfer
        IN_VALID = 1'b1; IN_DATA = 8'h77;
        tick();
        IN_VALID = 1'b0;
        tick();
        check("mid_req_up", {7'b0, TX_REQ}, 8'h01);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("mid_rst_req",   {7'b0, TX_REQ},   8'h00);
        check("mid_rst_data",  TX_DATA,          8'h00);
        check("mid_rst_ready", {7'b0, IN_READY}, 8'h01);
        check("mid_rst_done",  {7'b0, TX_DONE},  8'h00);
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (TX_DONE === 1'b1) done_seen = 1'b1;
        end
        check("mid_no_done",  {7'b0, done_seen}, 8'h00);
        check("mid_end_ready", {7'b0, IN_READY}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_cdc_hs_tx
